cdb_scheduler: RTL and testbench
================================

# cdb_scheduler

Sequencing controller for the common data bus. Each cycle it picks at most one functional unit with a finished result (`fu_status`) and drives `should_dispatch`/`victim` into the CDB arbiter, which then broadcasts that result and pulses `retiring_stations`. Fairness comes from a round-robin pointer, a priority mask and per-unit starvation counters, all held across cycles.

## Interface
- `FUNCTIONAL_UNIT_COUNT`, 3: number of requesters; legal range 2..8, because the CDB `rs_id` is 3 bits.
- `STARVE_LIMIT`, 4: waiting cycles after which a pending unit overrides all other selection; must be ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fu_status`  in  FUNCTIONAL_UNIT_COUNT  bit i = unit i holds a result awaiting broadcast.
- `fu_priority`  in  FUNCTIONAL_UNIT_COUNT  bit i = unit i is preferred this cycle; ignored unless `fu_status[i]`.
- `cdb_stall`  in  1  downstream cannot accept a broadcast this cycle.
- `flush`  in  1  pipeline flush; suppresses dispatch and clears fairness state.
- `should_dispatch`  out  1  a grant is issued this cycle.
- `victim`  out  $clog2(FUNCTIONAL_UNIT_COUNT)  granted unit index; 0 when no grant.
- `starve_override`  out  1  this grant came from the starvation rule (debug/perf).

## Operation
- State: `rr_ptr` (victim width) and `wait_cnt[i]` (width $clog2(STARVE_LIMIT+1), one per unit).
- Grant logic is combinational from the inputs and registered state.
- `should_dispatch = |fu_status & !cdb_stall & !flush & rst_n`.
- Selection order:
  - Starved set: units with `fu_status[i]` and `wait_cnt[i] == STARVE_LIMIT`. If non-empty, grant the lowest index in it and set `starve_override`.
  - Otherwise the priority set `fu_status & fu_priority`. If non-empty, grant the first member found searching circularly from `rr_ptr`.
  - Otherwise grant the first member of `fu_status` found searching circularly from `rr_ptr`.
- Circular search order is `rr_ptr`, `rr_ptr+1`, …, wrapping at FUNCTIONAL_UNIT_COUNT−1 → 0. Wrap is explicit because FUNCTIONAL_UNIT_COUNT need not be a power of 2.
- With no grant, `victim` = 0 and `starve_override` = 0. These values are defined, never X.
- On a grant to unit k: `rr_ptr <= (k == FUNCTIONAL_UNIT_COUNT−1) ? 0 : k+1`. With no grant, `rr_ptr` holds.
- `wait_cnt[i]` next value, first matching rule wins:
  - `flush`: 0.
  - `!fu_status[i]`, or unit i granted: 0.
  - Otherwise: +1, saturating at STARVE_LIMIT.
- Counters keep incrementing during `cdb_stall`. This bounds post-stall unfairness.
- `flush` clears all `wait_cnt` and leaves `rr_ptr` unchanged.
- Handshake contract: a unit deasserts `fu_status` on the cycle after its grant, driven by the arbiter's `retiring_stations`. If `fu_status` is still high in the next cycle, the unit is treated as a new request.

## Timing
- Grant latency is 0 cycles: `fu_status` in cycle t produces `should_dispatch`/`victim` in cycle t.
- State updates on the rising edge closing cycle t and affects selection in cycle t+1.
- Reset (`rst_n` low, asynchronous):
  - Immediately: `should_dispatch` = 0, `victim` = 0, `starve_override` = 0, `rr_ptr` = 0, all `wait_cnt` = 0.
  - These hold while `rst_n` stays low. Normal operation resumes on the first rising edge after release.
- A reset asserted mid-grant kills the grant in the same cycle.
- Simultaneous `flush` and `cdb_stall`: flush rules apply.
- Simultaneous starvation of several units: the lowest index wins. The others stay saturated and win on subsequent cycles.

## Structure
- Add to the shared types package: parameterised helper functions `rr_pick(mask, ptr)` (returns found flag + index) and `lowest_set(mask)`.
- Instantiate one sub-module, `cdb_rr_picker`: purely combinational circular first-one finder taking `mask` and `start`, returning `found` and `index`. It is used twice, for the priority set and for the full set.
- Counters and the pointer live in the top module.

## Test plan
- Reset, then `fu_status=3'b111` constant, no stall → `victim` sequence 0,1,2,0,1 with `should_dispatch`=1 every cycle.
- `fu_status=3'b111`, `fu_priority=3'b100`, `rr_ptr`=0 → grant 2, then `rr_ptr`=0, next grant 2 again while priority holds.
- `fu_status=3'b101`, `cdb_stall`=1 for 4 cycles, STARVE_LIMIT=4 → `should_dispatch`=0 during the stall. First cycle after the stall: `victim`=0 with `starve_override`=1. Next cycle: `victim`=2 with `starve_override`=1.
- After a grant to unit 2 (N=3) → `rr_ptr` wraps to 0. With `fu_status=3'b011`, next grant is 0.
- `flush` pulse with saturated counters → `should_dispatch`=0 that cycle. Counters read 0 afterwards and the next grant follows `rr_ptr` with `starve_override`=0.
- `rst_n` dropped asynchronously mid-cycle while `should_dispatch`=1 → outputs go to 0 before the next edge. After release, the first grant with `fu_status=3'b110` is unit 1.

Source files
------------

// File: rtl/cdb_scheduler_pkg.sv
// cdb_scheduler_pkg: shared types and selection helpers for the CDB scheduler
package cdb_scheduler_pkg;
  localparam int MAX_FU = 8;
  function automatic logic rr_pick(input logic [MAX_FU-1:0] mask, input logic [2:0] ptr, input int n, output int idx);
    logic found;
    int j;
    found = 1'b0;
    idx = 0;
    for (int k = MAX_FU - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && mask[j[2:0]]) begin
        found = 1'b1;
        idx = j;
      end
    end
    return found;
  endfunction
  function automatic logic lowest_set(input logic [MAX_FU-1:0] mask, output int idx);
    logic found;
    found = 1'b0;
    idx = 0;
    for (int k = MAX_FU - 1; k >= 0; k--) begin
      if (mask[k]) begin
        found = 1'b1;
        idx = k;
      end
    end
    return found;
  endfunction
endpackage

// File: rtl/cdb_scheduler_if.sv
// cdb_scheduler_if: request/grant bundle between functional units and the CDB scheduler
// master drives fu_status/fu_priority/cdb_stall/flush; slave returns should_dispatch/victim/starve_override
interface cdb_scheduler_if #(parameter int N = 3);
  localparam int W = $clog2(N);
  logic [N-1:0] fu_status;
  logic [N-1:0] fu_priority;
  logic cdb_stall;
  logic flush;
  logic should_dispatch;
  logic [W-1:0] victim;
  logic starve_override;
  modport master (output fu_status, fu_priority, cdb_stall, flush, input should_dispatch, victim, starve_override);
  modport slave (input fu_status, fu_priority, cdb_stall, flush, output should_dispatch, victim, starve_override);
endinterface

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: combinational circular first-one finder starting at start_i
// mask_i: candidates, start_i: first index searched, found_o: any candidate, index_o: chosen index
module cdb_rr_picker
  import cdb_scheduler_pkg::*;
#(
  parameter int N = 3,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] index_o
);
  always_comb begin
    int idx;
    idx = 0;
    found_o = rr_pick(MAX_FU'(mask_i), 3'(start_i), N, idx);
    index_o = W'(idx);
  end
endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: picks one finished functional unit per cycle for CDB broadcast
// clk, rst_n (async active-low); bus: slave side of cdb_scheduler_if (requests in, grant out)
module cdb_scheduler
  import cdb_scheduler_pkg::*;
#(
  parameter int FUNCTIONAL_UNIT_COUNT = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  cdb_scheduler_if.slave bus
);
  localparam int N = FUNCTIONAL_UNIT_COUNT;
  localparam int W = $clog2(N);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] SAT = CW'(STARVE_LIMIT);
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] wait_cnt_q [N];
  logic [CW-1:0] wait_cnt_d [N];
  logic [N-1:0] starved;
  logic go, starve_found, pri_found, all_found;
  logic [W-1:0] starve_idx, pri_idx, all_idx, pick;
  always_comb begin
    int s;
    starved = '0;
    for (int i = 0; i < N; i++) starved[i] = bus.fu_status[i] && wait_cnt_q[i] == SAT;
    s = 0;
    starve_found = lowest_set(MAX_FU'(starved), s);
    starve_idx = W'(s);
  end
  cdb_rr_picker #(.N(N)) u_pri (
    .mask_i  (bus.fu_status & bus.fu_priority),
    .start_i (rr_ptr_q),
    .found_o (pri_found),
    .index_o (pri_idx)
  );
  cdb_rr_picker #(.N(N)) u_all (
    .mask_i  (bus.fu_status),
    .start_i (rr_ptr_q),
    .found_o (all_found),
    .index_o (all_idx)
  );
  // rst_n is part of the grant term so an asserted reset kills a grant mid-cycle
  assign go = |bus.fu_status && !bus.cdb_stall && !bus.flush && rst_n;
  assign pick = starve_found ? starve_idx : pri_found ? pri_idx : all_found ? all_idx : '0;
  assign bus.should_dispatch = go;
  assign bus.victim = go ? pick : '0;
  assign bus.starve_override = go && starve_found;
  // explicit wrap: N need not be a power of two
  assign rr_ptr_d = go ? (pick == W'(N - 1) ? '0 : pick + 1'b1) : rr_ptr_q;
  // counters keep running through cdb_stall so post-stall unfairness stays bounded
  always_comb begin
    for (int i = 0; i < N; i++)
      wait_cnt_d[i] = (bus.flush || !bus.fu_status[i] || (go && pick == W'(i))) ? '0 :
                      wait_cnt_q[i] == SAT ? SAT : wait_cnt_q[i] + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < N; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end
endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed and randomized checks of cdb_scheduler against a behavioural model
module tb_cdb_scheduler;
  localparam int N = 3;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cdb_scheduler_if #(.N(N)) bus();
  cdb_scheduler #(.FUNCTIONAL_UNIT_COUNT(N), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  int m_wait [N];
  logic exp_sd, exp_so;
  logic [1:0] exp_v;
  function automatic int rr_first(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction
  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask
  task automatic eval_model();
    int s;
    s = -1;
    for (int i = N - 1; i >= 0; i--)
      if (bus.fu_status[i] && m_wait[i] == SL) s = i;
    exp_sd = (bus.fu_status != 0) && !bus.cdb_stall && !bus.flush && rst_n;
    exp_so = exp_sd && s >= 0;
    if (!exp_sd) exp_v = 2'd0;
    else if (s >= 0) exp_v = 2'(s);
    else if ((bus.fu_status & bus.fu_priority) != 0) exp_v = 2'(rr_first(bus.fu_status & bus.fu_priority));
    else exp_v = 2'(rr_first(bus.fu_status));
  endtask
  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int i = 0; i < N; i++)
        m_wait[i] = (bus.flush || !bus.fu_status[i] || (exp_sd && int'(exp_v) == i)) ? 0 :
                    (m_wait[i] < SL ? m_wait[i] + 1 : SL);
      if (exp_sd) m_ptr = (int'(exp_v) + 1) % N;
    end
    #1;
  endtask
  task automatic drive(input logic [N-1:0] st, input logic [N-1:0] pr, input logic stl, input logic fl);
    bus.fu_status = st;
    bus.fu_priority = pr;
    bus.cdb_stall = stl;
    bus.flush = fl;
  endtask
  task automatic test_reset();
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.should_dispatch !== 1'b0) begin errors++; $display("FAIL reset_sd got %b want 0", bus.should_dispatch); end
    checks++;
    if (bus.victim !== 2'd0) begin errors++; $display("FAIL reset_victim got %0d want 0", bus.victim); end
    checks++;
    if (bus.starve_override !== 1'b0) begin errors++; $display("FAIL reset_so got %b want 0", bus.starve_override); end
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 0, 1};
    for (int k = 0; k < 5; k++) begin
      drive(3'b111, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      eval_model();
      checks++;
      if (bus.should_dispatch !== 1'b1 || bus.victim !== 2'(seq[k]) || bus.starve_override !== 1'b0) begin
        errors++;
        $display("FAIL rr_seq[%0d] got sd=%b v=%0d so=%b want sd=1 v=%0d so=0", k, bus.should_dispatch, bus.victim, bus.starve_override, seq[k]);
      end
      advance();
    end
  endtask
  task automatic test_priority();
    drive(3'b100, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    eval_model();
    checks++;
    if (bus.victim !== 2'd2) begin errors++; $display("FAIL prio_setup got v=%0d want 2", bus.victim); end
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(3'b111, 3'b100, 1'b0, 1'b0);
      @(negedge clk);
      eval_model();
      checks++;
      if (bus.should_dispatch !== 1'b1 || bus.victim !== 2'd2 || bus.starve_override !== 1'b0) begin
        errors++;
        $display("FAIL prio_grant[%0d] got sd=%b v=%0d so=%b want sd=1 v=2 so=0", k, bus.should_dispatch, bus.victim, bus.starve_override);
      end
      advance();
    end
  endtask
  task automatic test_starve();
    drive(3'b000, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    eval_model();
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(3'b101, 3'b000, 1'b1, 1'b0);
      @(negedge clk);
      eval_model();
      checks++;
      if (bus.should_dispatch !== 1'b0 || bus.victim !== 2'd0) begin
        errors++;
        $display("FAIL stall_sd[%0d] got sd=%b v=%0d want sd=0 v=0", k, bus.should_dispatch, bus.victim);
      end
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      drive(3'b101, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      eval_model();
      checks++;
      if (bus.should_dispatch !== 1'b1 || bus.victim !== (k == 0 ? 2'd0 : 2'd2) || bus.starve_override !== 1'b1) begin
        errors++;
        $display("FAIL starve[%0d] got sd=%b v=%0d so=%b want sd=1 v=%0d so=1", k, bus.should_dispatch, bus.victim, bus.starve_override, k == 0 ? 0 : 2);
      end
      advance();
    end
  endtask
  task automatic test_wrap();
    drive(3'b011, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    eval_model();
    checks++;
    if (bus.victim !== 2'd0 || bus.starve_override !== 1'b0) begin
      errors++;
      $display("FAIL wrap got v=%0d so=%b want v=0 so=0", bus.victim, bus.starve_override);
    end
    advance();
  endtask
  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      drive(3'b111, 3'b000, 1'b1, 1'b0);
      @(negedge clk);
      eval_model();
      advance();
    end
    drive(3'b111, 3'b000, 1'b1, 1'b1);
    @(negedge clk);
    eval_model();
    checks++;
    if (bus.should_dispatch !== 1'b0) begin errors++; $display("FAIL flush_sd got %b want 0", bus.should_dispatch); end
    advance();
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    eval_model();
    checks++;
    if (bus.should_dispatch !== 1'b1 || bus.victim !== 2'd1 || bus.starve_override !== 1'b0) begin
      errors++;
      $display("FAIL post_flush got sd=%b v=%0d so=%b want sd=1 v=1 so=0", bus.should_dispatch, bus.victim, bus.starve_override);
    end
    advance();
  endtask
  task automatic test_async_reset();
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    eval_model();
    checks++;
    if (bus.should_dispatch !== 1'b1) begin errors++; $display("FAIL pre_areset_sd got %b want 1", bus.should_dispatch); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.should_dispatch !== 1'b0 || bus.victim !== 2'd0 || bus.starve_override !== 1'b0) begin
      errors++;
      $display("FAIL areset got sd=%b v=%0d so=%b want 0 0 0", bus.should_dispatch, bus.victim, bus.starve_override);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(3'b110, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    eval_model();
    checks++;
    if (bus.should_dispatch !== 1'b1 || bus.victim !== 2'd1) begin
      errors++;
      $display("FAIL post_areset got sd=%b v=%0d want sd=1 v=1", bus.should_dispatch, bus.victim);
    end
    advance();
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(3'($urandom), 3'($urandom), $urandom_range(3) == 0, $urandom_range(19) == 0);
      @(negedge clk);
      eval_model();
      checks++;
      if (bus.should_dispatch !== exp_sd || bus.victim !== exp_v || bus.starve_override !== exp_so) begin
        errors++;
        $display("FAIL random[%0d] st=%b pr=%b stall=%b flush=%b got sd=%b v=%0d so=%b want sd=%b v=%0d so=%b",
                 k, bus.fu_status, bus.fu_priority, bus.cdb_stall, bus.flush,
                 bus.should_dispatch, bus.victim, bus.starve_override, exp_sd, exp_v, exp_so);
      end
      advance();
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_starve();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
